// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: three-cycle ROM fetch (ADDR, LATCH, ISSUE) with jump and halt.
// Optional macro FETCH_CTRL_FETCH_CNT_EN enables a saturating count of accepted instructions.
module fetch_ctrl #(
   parameter int          ADDR_W  = 4,
   parameter int          DATA_W  = 8,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_read_en,
   input  logic [DATA_W-1:0] rom_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [3:0]        opcode,
   output logic [DATA_W-5:0] operand,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic [7:0]        fetch_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_LATCH = 3'd2,
      S_ISSUE = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic [3:0]          r_opcode;
   logic [3:0]          w_opcode_nxt;
   logic [DATA_W-5:0]   r_operand;
   logic [DATA_W-5:0]   w_operand_nxt;
   logic                w_accept;

   assign w_accept = (r_state == S_ISSUE) && instr_ready;

   // Next-state, program counter and instruction register update
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_opcode_nxt  = r_opcode;
      w_operand_nxt = r_operand;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_ADDR;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ADDR: begin
            w_state_nxt = S_LATCH;
         end
         S_LATCH: begin
            w_opcode_nxt  = rom_data[DATA_W-1:DATA_W-4];
            w_operand_nxt = rom_data[DATA_W-5:0];
            w_pc_nxt      = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            w_state_nxt   = S_ISSUE;
         end
         S_ISSUE: begin
            if (!instr_ready) begin
               w_state_nxt = S_ISSUE;
            end else if (r_opcode == HALT_OP) begin
               w_state_nxt = S_HALT;
            end else if (jump_en) begin
               w_pc_nxt    = jump_addr;
               w_state_nxt = S_ADDR;
            end else begin
               w_state_nxt = S_ADDR;
            end
         end
         S_HALT: begin
            if (start) begin
               w_pc_nxt    = {ADDR_W{1'b0}};
               w_state_nxt = S_ADDR;
            end else begin
               w_state_nxt = S_HALT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, program counter and instruction register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pc      <= {ADDR_W{1'b0}};
         r_opcode  <= 4'h0;
         r_operand <= {(DATA_W-4){1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_opcode  <= w_opcode_nxt;
         r_operand <= w_operand_nxt;
      end
   end

`ifdef FETCH_CTRL_FETCH_CNT_EN
   logic [7:0] r_fetch_count;

   // Saturating count of accepted instructions; only reset clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= 8'h00;
      end else if (w_accept && (r_fetch_count != 8'hFF)) begin
         r_fetch_count <= r_fetch_count + 8'h01;
      end else begin
         r_fetch_count <= r_fetch_count;
      end
   end

   assign fetch_count = r_fetch_count;
`else
   logic w_unused_accept;
   assign w_unused_accept = w_accept;
   assign fetch_count     = 8'h00;
`endif

   // Outputs are pure decodes of registered state, so no input reaches an output
   assign rom_read_en = (r_state == S_ADDR) || (r_state == S_LATCH);
   assign rom_addr    = rom_read_en ? r_pc : {ADDR_W{1'b0}};
   assign instr_valid = (r_state == S_ISSUE);
   assign busy        = (r_state == S_ADDR) || (r_state == S_LATCH) || (r_state == S_ISSUE);
   assign halted      = (r_state == S_HALT);
   assign pc          = r_pc;
   assign opcode      = r_opcode;
   assign operand     = r_operand;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, 4, ROM address width and program counter width.
REQ-002 Parameter DATA_W, 8, ROM word width: opcode is the upper 4 bits, operand is the lower DATA_W-4 bits.
REQ-003 Parameter HALT_OP, 4'hF, opcode value that halts fetching.
REQ-004 clk  in  1  single clock; all state changes occur on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  begin fetching; sampled only in IDLE or HALT.
REQ-007 rom_addr  out  ADDR_W  address to the ROM; equals pc while rom_read_en=1, otherwise 0.
REQ-008 rom_read_en  out  1  ROM output enable; the ROM drives Z while this is 0.
REQ-009 rom_data  in  DATA_W  ROM data; sampled only while rom_read_en=1.
REQ-010 instr_valid  out  1  opcode and operand hold a fetched instruction.
REQ-011 instr_ready  in  1  consumer accepts the instruction when instr_valid=1 and instr_ready=1 on the same edge.
REQ-012 opcode  out  4  instruction register, upper nibble.
REQ-013 operand  out  DATA_W-4  instruction register, lower bits.
REQ-014 jump_en  in  1  redirect the pc; sampled only on an accept edge.
REQ-015 jump_addr  in  ADDR_W  jump target.
REQ-016 pc  out  ADDR_W  program counter.
REQ-017 busy  out  1  high in the ADDR, LATCH and ISSUE states.
REQ-018 halted  out  1  high in the HALT state.
REQ-019 fetch_count  out  8  count of accepted instructions (see Configuration).

Function
REQ-020 The block SHALL implement five states: IDLE, ADDR, LATCH, ISSUE and HALT.
REQ-021 IDLE: when start=1, the pc SHALL be unchanged and the next state SHALL be ADDR; otherwise the block stays in IDLE.
REQ-022 ADDR: rom_read_en=1 and rom_addr=pc; the next state SHALL be LATCH unconditionally.
REQ-023 LATCH: rom_read_en=1 and rom_addr=pc; on the edge the block SHALL capture rom_data into opcode/operand, set pc to pc+1 modulo 2^ADDR_W (15 wraps to 0), and go to ISSUE.
REQ-024 ISSUE: instr_valid=1 and rom_read_en=0; opcode, operand and pc SHALL remain stable until accept.
REQ-025 On accept with opcode==HALT_OP, the next state SHALL be HALT; jump_en SHALL be ignored.
REQ-026 On accept with opcode!=HALT_OP and jump_en=1, pc SHALL be set to jump_addr and the next state SHALL be ADDR.
REQ-027 On accept with opcode!=HALT_OP and jump_en=0, the next state SHALL be ADDR.
REQ-028 HALT: rom_read_en=0, instr_valid=0 and halted=1; when start=1, pc SHALL be cleared to 0 and the next state SHALL be ADDR.
REQ-029 start SHALL be ignored while busy=1; jump_en SHALL be ignored except on an accept edge.
REQ-030 Latency: a start sampled at edge k SHALL give instr_valid=1 in the cycle after edge k+2; back-to-back instructions SHALL issue at most one per 3 cycles.
REQ-031 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for a clock edge, force: state=IDLE, pc=0, opcode=0, operand=0, rom_read_en=0, rom_addr=0, instr_valid=0, busy=0, halted=0, fetch_count=0.
REQ-033 A reset asserted in any state, including mid-read, SHALL abort the fetch with no capture; operation resumes only on a start after rst is released.

Configuration
REQ-034 Macro FETCH_CTRL_FETCH_CNT_EN, when defined: fetch_count SHALL increment by 1 on each accept edge, saturate at 8'hFF, and not be cleared by start.
REQ-035 Macro FETCH_CTRL_FETCH_CNT_EN, when not defined: fetch_count SHALL be tied to 8'h00 and no counter register SHALL exist.

Verification
REQ-036 ROM loaded {10,2A,A0,40,10,F0,00...}, instr_ready=1, start pulsed once -> accepted words 0x10, 0x2A, 0xA0, 0x40, 0x10, 0xF0 in order; then halted=1, pc=6, rom_read_en=0 permanently.
REQ-037 instr_ready held at 0 for 5 cycles at address 1 -> instr_valid=1, opcode=2 and operand=A steady, pc=2, rom_read_en=0 for all 5 cycles.
REQ-038 jump_en=1 with jump_addr=3 on the accept of address 1 -> the next rom_addr is 3 and the next instruction is 0x40.
REQ-039 Jump to 15 -> instruction 0x00 fetched, then pc=0, and the next fetch reads address 0 (0x10).
REQ-040 rst pulsed during LATCH -> all outputs are 0 before the next edge; start afterwards -> the first instruction is 0x10.
REQ-041 FETCH_CTRL_FETCH_CNT_EN defined, after the REQ-036 run -> fetch_count=6; macro undefined -> fetch_count=0 throughout.
